inst_boot_loader: RTL and testbench

- Hardware successor to the bench-driven instruction preload flow.
- Accepts an instruction-word stream over a valid/ready handshake and writes it into instruction memory through the load port (`load_en` / `Inst_addr_load` / `Inst_load`).
- Pads unused locations with a fill word, then releases core reset after a programmable delay.
- Sits between a boot source (UART/SPI/debug bridge) and `cpu_top`. It owns the core reset while loading.

---
 rtl/inst_boot_loader.sv | 201 ++++++++++++++++++++
 tb/tb_inst_boot_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : inst_boot_loader
// Brief    : Streams instruction words into imem, pads with FILL_WORD, then
//            releases core reset. Optional macro: INST_BOOT_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module inst_boot_loader #(
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DEPTH       = 256,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0]    ADDR_STEP   = ADDR_W'(4),
    parameter logic [DATA_W-1:0]    FILL_WORD   = '0,
    parameter int unsigned          RELEASE_DLY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        src_valid,
    input  logic [DATA_W-1:0]           src_data,
    input  logic                        src_last,
`ifdef INST_BOOT_CHECKSUM_EN
    input  logic [DATA_W-1:0]           exp_sum,
`endif
    output logic                        src_ready,
    output logic                        load_en,
    output logic [ADDR_W-1:0]           Inst_addr_load,
    output logic [DATA_W-1:0]           Inst_load,
    output logic                        core_rst_n,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(DEPTH+1)-1:0]  word_count,
    output logic                        err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned DLY_W = (RELEASE_DLY > 0) ? $clog2(RELEASE_DLY + 1) : 1;
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DEPTH - 1);
    localparam logic [DLY_W-1:0] c_dly_last = DLY_W'(RELEASE_DLY);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
`ifdef INST_BOOT_CHECKSUM_EN
        , ST_ERROR = 3'd5
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic                load_en_q, load_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DLY_W-1:0]    dly_q, dly_d;

    logic                w_busy;
    logic                w_stream_end;
    logic [ADDR_W-1:0]   w_addr;
    state_t              w_load_exit_st;
    state_t              w_fill_exit_st;

    assign w_busy       = (state_q == ST_LOAD) || (state_q == ST_FILL) || (state_q == ST_HOLD);
    assign w_stream_end = src_last || (idx_q == c_idx_last);
    assign w_addr       = BASE_ADDR + ADDR_W'(idx_q) * ADDR_STEP;

`ifdef INST_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                bad_q, bad_d;
    logic [DATA_W-1:0]   w_sum_next;
    logic                w_bad_now;

    // The checksum covers the word being accepted in the same cycle.
    assign w_sum_next     = sum_q + src_data;
    assign w_bad_now      = (w_sum_next != exp_sum);
    assign w_load_exit_st = w_bad_now ? ST_ERROR : ST_HOLD;
    assign w_fill_exit_st = bad_q ? ST_ERROR : ST_HOLD;
`else
    assign w_load_exit_st = ST_HOLD;
    assign w_fill_exit_st = ST_HOLD;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_count_d = word_count_q;
        load_en_d    = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        dly_d        = dly_q;
`ifdef INST_BOOT_CHECKSUM_EN
        sum_d        = sum_q;
        bad_d        = bad_q;
`endif
        if (start && !w_busy) begin
            state_d      = ST_LOAD;
            idx_d        = '0;
            word_count_d = '0;
`ifdef INST_BOOT_CHECKSUM_EN
            sum_d        = '0;
            bad_d        = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (src_valid) begin
                        load_en_d    = 1'b1;
                        addr_d       = w_addr;
                        data_d       = src_data;
                        idx_d        = idx_q + IDX_W'(1);
                        word_count_d = word_count_q + CNT_W'(1);
`ifdef INST_BOOT_CHECKSUM_EN
                        sum_d        = w_sum_next;
`endif
                        if (w_stream_end) begin
                            dly_d = '0;
`ifdef INST_BOOT_CHECKSUM_EN
                            bad_d = w_bad_now;
`endif
                            if (idx_q != c_idx_last) begin
                                state_d = ST_FILL;
                            end else begin
                                state_d = w_load_exit_st;
                            end
                        end
                    end
                end
                ST_FILL: begin
                    load_en_d = 1'b1;
                    addr_d    = w_addr;
                    data_d    = FILL_WORD;
                    idx_d     = idx_q + IDX_W'(1);
                    if (idx_q == c_idx_last) begin
                        dly_d   = '0;
                        state_d = w_fill_exit_st;
                    end
                end
                ST_HOLD: begin
                    // The first HOLD cycle is the cycle of the final write.
                    if (dly_q == c_dly_last) begin
                        state_d = ST_DONE;
                    end else begin
                        dly_d = dly_q + DLY_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            word_count_q <= '0;
            load_en_q    <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            dly_q        <= '0;
`ifdef INST_BOOT_CHECKSUM_EN
            sum_q        <= '0;
            bad_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            word_count_q <= word_count_d;
            load_en_q    <= load_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            dly_q        <= dly_d;
`ifdef INST_BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
            bad_q        <= bad_d;
`endif
        end
    end

    assign src_ready      = (state_q == ST_LOAD);
    assign load_en        = load_en_q;
    assign Inst_addr_load = addr_q;
    assign Inst_load      = data_q;
    assign core_rst_n     = (state_q == ST_DONE);
    assign busy           = w_busy;
    assign done           = (state_q == ST_DONE);
    assign word_count     = word_count_q;
`ifdef INST_BOOT_CHECKSUM_EN
    assign err            = (state_q == ST_ERROR);
`else
    assign err            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_inst_boot_loader
// Brief    : Randomized scoreboard bench for inst_boot_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_boot_loader;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 256;
    localparam int          RDLY   = 2;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] STEP   = 32'd4;
    localparam logic [31:0] FILL   = 32'hA5A5_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              src_valid;
    logic [31:0]       src_data;
    logic              src_last;
    logic              src_ready;
    logic              load_en;
    logic [31:0]       Inst_addr_load;
    logic [31:0]       Inst_load;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic [8:0]        word_count;
    logic              err;
`ifdef INST_BOOT_CHECKSUM_EN
    logic [31:0]       exp_sum;
`endif

    inst_boot_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .ADDR_STEP(STEP), .FILL_WORD(FILL), .RELEASE_DLY(RDLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
`ifdef INST_BOOT_CHECKSUM_EN
        .exp_sum(exp_sum),
`endif
        .src_ready(src_ready), .load_en(load_en),
        .Inst_addr_load(Inst_addr_load), .Inst_load(Inst_load),
        .core_rst_n(core_rst_n), .busy(busy), .done(done),
        .word_count(word_count), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  exp_last_wr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] addr_of(input int k);
        return BASE + 32'(k) * STEP;
    endfunction

    // Monitor: every write strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        wr_t e;
        if (load_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(Inst_addr_load), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr",  64'(Inst_addr_load), 64'(e.addr));
                chk("wr_data",  64'(Inst_load),      64'(e.data));
                chk("wr_cycle", 64'(cyc),            64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stall(input int n);
        for (int s = 0; s < n; s++) begin
            src_valid = 1'b0;
            src_data  = $urandom;
            src_last  = 1'($urandom_range(0, 1));
            tick();
        end
        src_last = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_load_en"},   64'(load_en),        64'd0);
        chk({tag, "_addr"},      64'(Inst_addr_load), 64'd0);
        chk({tag, "_data"},      64'(Inst_load),      64'd0);
        chk({tag, "_src_ready"}, 64'(src_ready),      64'd0);
        chk({tag, "_core_rst"},  64'(core_rst_n),     64'd0);
        chk({tag, "_busy"},      64'(busy),           64'd0);
        chk({tag, "_done"},      64'(done),           64'd0);
        chk({tag, "_wcount"},    64'(word_count),     64'd0);
        chk({tag, "_err"},       64'(err),            64'd0);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input bit rand_start,
                             input int idx, output int acc_cyc);
        wr_t e;
        src_valid = 1'b1;
        src_data  = d;
        src_last  = last;
        if (rand_start) start = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("src_ready",      64'(src_ready),  64'd1);
        chk("busy_in_load",   64'(busy),       64'd1);
        chk("core_rst_load",  64'(core_rst_n), 64'd0);
        chk("word_count_run", 64'(word_count), 64'(idx));
        e.addr = addr_of(idx);
        e.data = d;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        acc_cyc = cyc;
        tick();
        src_valid = 1'b0;
        src_last  = 1'b0;
        start     = 1'b0;
    endtask

    task automatic run_stream(input int n, input int max_stall, input bit use_last,
                              input bit rand_start, input logic [31:0] base_data,
                              input bit rnd, input bit bad_sum);
        int          acc;
        logic [31:0] d;
        logic [31:0] sum;
        wr_t         e;
        sum = '0;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            stall($urandom_range(0, max_stall));
            d   = rnd ? $urandom : base_data + 32'(i);
            sum = sum + d;
`ifdef INST_BOOT_CHECKSUM_EN
            if (i == n - 1) exp_sum = sum + (bad_sum ? 32'd1 : 32'd0);
`endif
            send_word(d, use_last && (i == n - 1), rand_start, i, acc);
        end
        for (int k = n; k < DEPTH; k++) begin
            e.addr = addr_of(k);
            e.data = FILL;
            e.cyc  = acc + 1 + (k - n + 1);
            exp_q.push_back(e);
        end
        exp_last_wr = acc + 1 + (DEPTH - n);
        // A word offered once the stream has ended must be refused.
        src_valid = 1'b1;
        src_data  = $urandom;
        src_last  = 1'b1;
        @(negedge clk);
        chk("src_ready_after_end", 64'(src_ready), 64'd0);
        tick();
        src_valid = 1'b0;
        src_last  = 1'b0;
        if (bad_sum) acc = 0;
    endtask

    task automatic wait_release(input int n, input bit expect_err);
        int t = 0;
        @(negedge clk);
        while (!(done === 1'b1 || err === 1'b1) && t < 2 * DEPTH + 50) begin
            @(negedge clk);
            t++;
        end
        if (!expect_err) chk("release_cycle", 64'(cyc), 64'(exp_last_wr + 1 + RDLY));
        chk("queue_drained",    64'(exp_q.size()), 64'd0);
        chk("final_done",       64'(done),         64'(!expect_err));
        chk("final_core_rst_n", 64'(core_rst_n),   64'(!expect_err));
        chk("final_err",        64'(err),          64'(expect_err));
        chk("final_busy",       64'(busy),         64'd0);
        chk("final_word_count", 64'(word_count),   64'(n));
        tick();
    endtask

    task automatic do_load(input int n, input int max_stall, input bit use_last,
                           input bit rand_start, input logic [31:0] base_data,
                           input bit rnd, input bit bad_sum);
        bit expect_err;
`ifdef INST_BOOT_CHECKSUM_EN
        expect_err = bad_sum;
`else
        expect_err = 1'b0;
`endif
        pulse_start();
        chk("start_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("start_done",       64'(done),       64'd0);
        chk("start_err",        64'(err),        64'd0);
        chk("start_busy",       64'(busy),       64'd1);
        chk("start_wcount",     64'(word_count), 64'd0);
        run_stream(n, max_stall, use_last, rand_start, base_data, rnd, bad_sum);
        wait_release(n, expect_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        rst_n     = 1'b0;
        start     = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        src_last  = 1'b0;
`ifdef INST_BOOT_CHECKSUM_EN
        exp_sum   = '0;
`endif
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst_n = 1'b1;
        stall(2);
        @(negedge clk);
        check_zero("idle");
        tick();

        do_load(DEPTH, 0, 1'b0, 1'b0, 32'h0000_0013, 1'b0, 1'b0);
        do_load(4,     0, 1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b0);
        do_load(1,     2, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        do_load(int'($urandom_range(2, 60)), 2, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
        do_load(DEPTH, 1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);

        // Abort in the middle of a load.
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            stall($urandom_range(0, 1));
            send_word($urandom, 1'b0, 1'b0, i, acc);
        end
        rst_n     = 1'b0;
        src_valid = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check_zero("midreset");
        chk("midreset_queue", 64'(exp_q.size()), 64'd0);
        tick();
        src_valid = 1'b0;
        rst_n     = 1'b1;
        stall(3);

        do_load(5, 1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            do_load(int'($urandom_range(1, 80)), 3, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
        end

`ifdef INST_BOOT_CHECKSUM_EN
        do_load(3, 0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b1);
        stall(4);
        @(negedge clk);
        chk("error_hold_err",      64'(err),        64'd1);
        chk("error_hold_core_rst", 64'(core_rst_n), 64'd0);
        tick();
        do_load(3, 0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
        do_load(int'($urandom_range(2, 40)), 2, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        do_load(int'($urandom_range(2, 40)), 2, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
